snow64_direct_mapped_instr_cache: RTL and testbench
===================================================

SNOW64_DIRECT_MAPPED_INSTR_CACHE -- requirements
Module: snow64_direct_mapped_instr_cache

Interface
REQ-001 Parameter NUM_LINES, default 8, line count (power of two, >=2).
REQ-002 Parameter LINE_WIDTH, default 256, line data bits (power-of-two multiple of INSTR_WIDTH).
REQ-003 Parameter INSTR_WIDTH, default 32, instruction bits.
REQ-004 Parameter ADDR_WIDTH, default 64, byte address bits.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  async active-low reset.
REQ-008 req_read_req  in  1  fetch request, held by requester until req_read_valid.
REQ-009 req_read_addr  in  ADDR_WIDTH  fetch byte address.
REQ-010 req_read_valid  out  1  one-cycle pulse: req_read_instr is valid.
REQ-011 req_read_instr  out  INSTR_WIDTH  fetched instruction.
REQ-012 flush  in  1  invalidate all lines.
REQ-013 mem_req  out  1  one-cycle line-fill request pulse.
REQ-014 mem_addr  out  ADDR_WIDTH  line-aligned fill address (low log2(LINE_WIDTH/8) bits zero).
REQ-015 mem_valid  in  1  fill data present this cycle.
REQ-016 mem_data  in  LINE_WIDTH  fill line.
REQ-017 hit_count, miss_count  out  32 each  wrapping performance counters.

Function
REQ-018 Address split, LSB first: byte offset log2(INSTR_WIDTH/8), word offset log2(LINE_WIDTH/INSTR_WIDTH), index log2(NUM_LINES), tag = remaining bits.
REQ-019 Per line: valid bit, tag, data; direct mapped.
REQ-020 States: ST_IDLE, ST_WAIT_MEM.
REQ-021 ST_IDLE, req_read_req, valid line with matching tag (hit): next edge req_read_valid=1, req_read_instr=selected word, hit_count+1; stay ST_IDLE.
REQ-022 ST_IDLE, req_read_req, miss: next edge mem_req=1, mem_addr=aligned address, miss_count+1, capture index/tag/word offset, go ST_WAIT_MEM.
REQ-023 ST_WAIT_MEM: mem_req=0; requests ignored; on mem_valid next edge install mem_data, set valid and tag, req_read_valid=1, req_read_instr=captured word of mem_data, go ST_IDLE.
REQ-024 req_read_valid SHALL be 0 in every cycle not covered by REQ-021/REQ-023; miss-to-valid latency = mem latency + 1 cycle.
REQ-025 Requester drops req_read_req the cycle after req_read_valid; a request held past that is treated as a new fetch.
REQ-026 flush SHALL clear all valid bits at the next edge, in any state.
REQ-027 flush with a hit in ST_IDLE, same cycle: flush wins; request handled as miss.
REQ-028 flush during ST_WAIT_MEM (including the mem_valid cycle): fill data still returned to requester; line NOT marked valid.
REQ-029 Refill of an occupied index SHALL overwrite the old tag/data.
REQ-030 Counters SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-031 On rst_n low: state ST_IDLE; all valid bits 0; req_read_valid, req_read_instr, mem_req, mem_addr, hit_count, miss_count all 0; asynchronous assertion, synchronous release.
REQ-032 Reset mid-fill abandons the fill; a later mem_valid in ST_IDLE SHALL be ignored.
REQ-033 Line data and tag arrays need no reset.

Structure
REQ-034 State enum and default-width constants SHALL live in a shared instruction-cache package alongside existing cache port structs.
REQ-035 Tag/data/valid storage SHALL be a sub-module snow64_icache_line_array (one write port, one async read port, bulk valid clear).

Verification (default parameters)
REQ-036 Reset, req 0x100 -> 1 cycle later mem_req=1, mem_addr=0x100; mem_valid with word k = 0xA0+k -> next cycle valid=1, instr=0xA0, miss_count=1.
REQ-037 Then req 0x11C -> valid next cycle, instr=0xA7, no mem_req, hit_count=1.
REQ-038 Req 0x200 (same index 0) -> miss, fill word0=0xB0; then req 0x100 -> miss again (evicted).
REQ-039 flush same cycle as mem_valid for 0x120 -> instr returned; re-request 0x120 -> miss.
REQ-040 rst_n low in ST_WAIT_MEM, then mem_valid pulse -> no req_read_valid; req 0x100 -> miss, counters restart from 0.
REQ-041 Counter wrap: preload via 2^32 hits (or forced) -> hit_count 0xFFFFFFFF then 0.

Source files
------------

// File: rtl/snow64_direct_mapped_instr_cache_pkg.sv
// Shared instruction-cache definitions: FSM state, default geometry and the
// request/response structs used by fetch-side ports.
package snow64_direct_mapped_instr_cache_pkg;
  localparam int DEF_NUM_LINES   = 8;
  localparam int DEF_LINE_WIDTH  = 256;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH  = 64;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                      req;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } icache_read_req_t;

  typedef struct packed {
    logic                       valid;
    logic [DEF_INSTR_WIDTH-1:0] instr;
  } icache_read_resp_t;

  typedef struct packed {
    logic                      req;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } icache_mem_req_t;
endpackage

// File: rtl/snow64_direct_mapped_instr_cache_if.sv
// Fetch, line-fill and counter signals of the instruction cache.
interface snow64_direct_mapped_instr_cache_if
  import snow64_direct_mapped_instr_cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH
);
  logic                   req_read_req;
  logic [ADDR_WIDTH-1:0]  req_read_addr;
  logic                   req_read_valid;
  logic [INSTR_WIDTH-1:0] req_read_instr;
  logic                   flush;
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_valid;
  logic [LINE_WIDTH-1:0]  mem_data;
  logic [31:0]            hit_count;
  logic [31:0]            miss_count;

  modport slave (
    input  req_read_req, req_read_addr, flush, mem_valid, mem_data,
    output req_read_valid, req_read_instr, mem_req, mem_addr, hit_count, miss_count
  );
  modport master (
    output req_read_req, req_read_addr, flush, mem_valid, mem_data,
    input  req_read_valid, req_read_instr, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/snow64_icache_line_array.sv
// Direct-mapped line storage: one write port, async read, bulk valid clear.
module snow64_icache_line_array #(
  parameter int NUM_LINES  = 8,
  parameter int TAG_WIDTH  = 56,
  parameter int LINE_WIDTH = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_all,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_LINES)-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0]         wr_tag,
  input  logic [LINE_WIDTH-1:0]        wr_data,
  input  logic [$clog2(NUM_LINES)-1:0] rd_idx,
  output logic                         rd_valid,
  output logic [TAG_WIDTH-1:0]         rd_tag,
  output logic [LINE_WIDTH-1:0]        rd_data
);
  logic [NUM_LINES-1:0]                 valid_q;
  logic [NUM_LINES-1:0][TAG_WIDTH-1:0]  tag_q;
  logic [NUM_LINES-1:0][LINE_WIDTH-1:0] data_q;

  // Clear beats a same-cycle write so a flushed fill never becomes visible.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         valid_q         <= '0;
    else if (clear_all) valid_q         <= '0;
    else if (wr_en)     valid_q[wr_idx] <= 1'b1;

  always_ff @(posedge clk)
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/snow64_direct_mapped_instr_cache.sv
// Direct-mapped instruction cache: single outstanding line fill, one-cycle hits,
// wrapping hit/miss counters.
module snow64_direct_mapped_instr_cache
  import snow64_direct_mapped_instr_cache_pkg::*;
#(
  parameter int NUM_LINES   = DEF_NUM_LINES,
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input logic clk,
  input logic rst_n,
  snow64_direct_mapped_instr_cache_if.slave bus
);
  localparam int BYTE_OFF_W = $clog2(INSTR_WIDTH/8);
  localparam int WORD_OFF_W = $clog2(LINE_WIDTH/INSTR_WIDTH);
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int LINE_OFF_W = BYTE_OFF_W + WORD_OFF_W;
  localparam int TAG_W      = ADDR_WIDTH - LINE_OFF_W - IDX_W;
  localparam int WORDS      = LINE_WIDTH/INSTR_WIDTH;

  icache_state_t state, state_nxt;
  logic [WORD_OFF_W-1:0] req_word, cap_word, cap_word_nxt;
  logic [IDX_W-1:0]      req_idx, cap_idx, cap_idx_nxt;
  logic [TAG_W-1:0]      req_tag, cap_tag, cap_tag_nxt;
  logic                  fill_flushed, fill_flushed_nxt;
  logic                  valid_nxt, mem_req_nxt;
  logic [INSTR_WIDTH-1:0] instr_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [31:0]           hit_nxt, miss_nxt;
  logic                  line_valid, hit, install, unused_addr_bits;
  logic [TAG_W-1:0]      line_tag;
  logic [LINE_WIDTH-1:0] line_data;
  logic [WORDS-1:0][INSTR_WIDTH-1:0] line_words, fill_words;

  assign req_word   = bus.req_read_addr[LINE_OFF_W-1:BYTE_OFF_W];
  assign req_idx    = bus.req_read_addr[LINE_OFF_W+IDX_W-1:LINE_OFF_W];
  assign req_tag    = bus.req_read_addr[ADDR_WIDTH-1:LINE_OFF_W+IDX_W];
  assign unused_addr_bits = ^bus.req_read_addr[BYTE_OFF_W-1:0];
  assign line_words = line_data;
  assign fill_words = bus.mem_data;

  // A same-cycle flush turns a would-be hit into a miss.
  assign hit     = line_valid && (line_tag == req_tag) && !bus.flush;
  // Any flush seen since the fill started keeps the returned line invalid.
  assign install = (state == ST_WAIT_MEM) && bus.mem_valid && !bus.flush && !fill_flushed;

  snow64_icache_line_array #(
    .NUM_LINES(NUM_LINES), .TAG_WIDTH(TAG_W), .LINE_WIDTH(LINE_WIDTH)
  ) u_lines (
    .clk(clk), .rst_n(rst_n), .clear_all(bus.flush),
    .wr_en(install), .wr_idx(cap_idx), .wr_tag(cap_tag), .wr_data(bus.mem_data),
    .rd_idx(req_idx), .rd_valid(line_valid), .rd_tag(line_tag), .rd_data(line_data)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt        = state;
    cap_word_nxt     = cap_word;
    cap_idx_nxt      = cap_idx;
    cap_tag_nxt      = cap_tag;
    fill_flushed_nxt = fill_flushed | bus.flush;
    valid_nxt        = 1'b0;
    mem_req_nxt      = 1'b0;
    instr_nxt        = bus.req_read_instr;
    mem_addr_nxt     = bus.mem_addr;
    hit_nxt          = bus.hit_count;
    miss_nxt         = bus.miss_count;
    case (state)
      ST_IDLE: if (bus.req_read_req) begin
        if (hit) begin
          valid_nxt = 1'b1;
          instr_nxt = line_words[req_word];
          hit_nxt   = bus.hit_count + 32'd1;
        end else begin
          mem_req_nxt      = 1'b1;
          mem_addr_nxt     = {bus.req_read_addr[ADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          miss_nxt         = bus.miss_count + 32'd1;
          cap_word_nxt     = req_word;
          cap_idx_nxt      = req_idx;
          cap_tag_nxt      = req_tag;
          fill_flushed_nxt = 1'b0;
          state_nxt        = ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: if (bus.mem_valid) begin
        valid_nxt = 1'b1;
        instr_nxt = fill_words[cap_word];
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.req_read_valid <= 1'b0;
      bus.req_read_instr <= '0;
      bus.mem_req        <= 1'b0;
      bus.mem_addr       <= '0;
      bus.hit_count      <= '0;
      bus.miss_count     <= '0;
      cap_word           <= '0;
      cap_idx            <= '0;
      cap_tag            <= '0;
      fill_flushed       <= 1'b0;
    end else begin
      bus.req_read_valid <= valid_nxt;
      bus.req_read_instr <= instr_nxt;
      bus.mem_req        <= mem_req_nxt;
      bus.mem_addr       <= mem_addr_nxt;
      bus.hit_count      <= hit_nxt;
      bus.miss_count     <= miss_nxt;
      cap_word           <= cap_word_nxt;
      cap_idx            <= cap_idx_nxt;
      cap_tag            <= cap_tag_nxt;
      fill_flushed       <= fill_flushed_nxt;
    end
endmodule

// File: tb/tb_snow64_direct_mapped_instr_cache.sv
// Directed plus randomized fetch sequences checked against a line-level cache model.
module tb_snow64_direct_mapped_instr_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snow64_direct_mapped_instr_cache_if ifc ();
  snow64_direct_mapped_instr_cache dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int checks = 0;
  int errors = 0;

  // Model: per-index valid/tag/line, plus expected counters.
  bit           mval [8];
  logic [55:0]  mtag [8];
  logic [255:0] mdat [8];
  logic [31:0]  exp_hits = 0;
  logic [31:0]  exp_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mval[i]) mval[i] = 1'b0;
  endtask

  function automatic logic [255:0] seq_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // Called at a negedge; returns at a negedge with the response visible.
  task automatic fetch(input logic [63:0] a, input logic [255:0] line, input int lat,
                       input bit fl_req, input bit fl_fill);
    int idx  = int'(a[7:5]);
    int word = int'(a[4:2]);
    logic [55:0] tag = a[63:8];
    bit h = mval[idx] && (mtag[idx] == tag) && !fl_req;
    if (fl_req) model_clear();
    ifc.req_read_req  = 1'b1;
    ifc.req_read_addr = a;
    ifc.flush         = fl_req;
    @(negedge clk);
    ifc.flush = 1'b0;
    if (h) begin
      exp_hits = exp_hits + 1;
      chk("hit_valid", 64'(ifc.req_read_valid), 64'd1);
      chk("hit_instr", 64'(ifc.req_read_instr), 64'(mdat[idx][word*32 +: 32]));
      chk("hit_no_mem_req", 64'(ifc.mem_req), 64'd0);
      chk("hit_count", 64'(ifc.hit_count), 64'(exp_hits));
      ifc.req_read_req = 1'b0;
    end else begin
      exp_miss = exp_miss + 1;
      chk("miss_valid_low", 64'(ifc.req_read_valid), 64'd0);
      chk("miss_mem_req", 64'(ifc.mem_req), 64'd1);
      chk("miss_mem_addr", ifc.mem_addr, {a[63:5], 5'b0});
      chk("miss_count", 64'(ifc.miss_count), 64'(exp_miss));
      ifc.flush = fl_fill;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        ifc.flush = 1'b0;
        chk("wait_valid_low", 64'(ifc.req_read_valid), 64'd0);
        chk("wait_mem_req_low", 64'(ifc.mem_req), 64'd0);
      end
      ifc.mem_valid = 1'b1;
      ifc.mem_data  = line;
      @(negedge clk);
      ifc.mem_valid    = 1'b0;
      ifc.flush        = 1'b0;
      ifc.req_read_req = 1'b0;
      chk("fill_valid", 64'(ifc.req_read_valid), 64'd1);
      chk("fill_instr", 64'(ifc.req_read_instr), 64'(line[word*32 +: 32]));
      if (fl_fill) model_clear();
      else begin
        mval[idx] = 1'b1;
        mtag[idx] = tag;
        mdat[idx] = line;
      end
    end
  endtask

  initial begin
    logic [255:0] line_a, line_b, line_c;
    line_a = seq_line(32'hA0);
    line_b = seq_line(32'hB0);
    line_c = seq_line(32'hC0);
    model_clear();
    ifc.req_read_req = 1'b0; ifc.req_read_addr = '0; ifc.flush = 1'b0;
    ifc.mem_valid = 1'b0;    ifc.mem_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(ifc.req_read_valid), 64'd0);
    chk("rst_instr", 64'(ifc.req_read_instr), 64'd0);
    chk("rst_mem_req", 64'(ifc.mem_req), 64'd0);
    chk("rst_mem_addr", ifc.mem_addr, 64'd0);
    chk("rst_hits", 64'(ifc.hit_count), 64'd0);
    chk("rst_miss", 64'(ifc.miss_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss then hit in the same line.
    fetch(64'h100, line_a, 2, 0, 0);
    chk("d_first_instr", 64'(ifc.req_read_instr), 64'hA0);
    chk("d_first_miss", 64'(ifc.miss_count), 64'd1);
    fetch(64'h11C, line_a, 0, 0, 0);
    chk("d_hit_instr", 64'(ifc.req_read_instr), 64'hA7);
    chk("d_hit_count", 64'(ifc.hit_count), 64'd1);
    // Conflict eviction at index 0.
    fetch(64'h200, line_b, 1, 0, 0);
    chk("d_evict_instr", 64'(ifc.req_read_instr), 64'hB0);
    fetch(64'h100, line_a, 1, 0, 0);
    chk("d_reload_miss", 64'(ifc.miss_count), 64'd3);
    // Flush alongside a would-be hit forces a miss.
    fetch(64'h104, line_a, 0, 1, 0);
    chk("d_flush_hit_miss", 64'(ifc.miss_count), 64'd4);
    // Flush on the fill cycle: data returned, line stays invalid.
    fetch(64'h120, line_c, 0, 0, 1);
    chk("d_flush_fill_instr", 64'(ifc.req_read_instr), 64'hC0);
    fetch(64'h120, line_c, 1, 0, 0);
    chk("d_flush_refetch_miss", 64'(ifc.miss_count), 64'd6);

    // Reset in the middle of a fill, stray mem_valid afterwards.
    ifc.req_read_req = 1'b1; ifc.req_read_addr = 64'h100;
    @(negedge clk);
    chk("r_mem_req", 64'(ifc.mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("r_async_mem_req", 64'(ifc.mem_req), 64'd0);
    chk("r_async_miss", 64'(ifc.miss_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; ifc.req_read_req = 1'b0;
    ifc.mem_valid = 1'b1; ifc.mem_data = line_b;
    @(negedge clk);
    ifc.mem_valid = 1'b0;
    chk("r_stray_fill_ignored", 64'(ifc.req_read_valid), 64'd0);
    model_clear(); exp_hits = 0; exp_miss = 0;
    fetch(64'h100, line_a, 0, 0, 0);
    chk("r_restart_miss", 64'(ifc.miss_count), 64'd1);

    // Random traffic over a small tag range so hits, conflicts and flushes mix.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ifc.flush = 1'b1;
        @(negedge clk);
        ifc.flush = 1'b0;
        model_clear();
        chk("rnd_idle_valid", 64'(ifc.req_read_valid), 64'd0);
      end else begin
        logic [63:0] a;
        a = {56'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
        fetch(a, rand_line(), int'($urandom_range(0, 3)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
    end
    chk("rnd_hits", 64'(ifc.hit_count), 64'(exp_hits));
    chk("rnd_miss", 64'(ifc.miss_count), 64'(exp_miss));

    // Counter wrap: preload just below the top, then two hits.
    fetch(64'h300, line_c, 0, 0, 0);
    force ifc.hit_count = 32'hFFFF_FFFE;
    #1;
    release ifc.hit_count;
    exp_hits = 32'hFFFF_FFFE;
    chk("w_preload", 64'(ifc.hit_count), 64'hFFFF_FFFE);
    @(negedge clk);
    fetch(64'h304, line_c, 0, 0, 0);
    chk("w_max", 64'(ifc.hit_count), 64'hFFFF_FFFF);
    fetch(64'h308, line_c, 0, 0, 0);
    chk("w_wrap", 64'(ifc.hit_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
